// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: takes a target word and drives the J/K inputs of
// WIDTH external JK flip-flops for exactly one clock edge so that their q
// outputs become that target. One edge later it reads q_fb back and reports
// done (match) or err (mismatch). It keeps a saturating 8-bit count of errors.
//
// Handshake: a target transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. in_valid does not need to be held after the
// transfer, and in_valid/in_target are ignored while busy.
module jk_excitation_driver #(
    parameter int WIDTH      = 4,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] w_k_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [7:0]       r_err_count;
    logic [7:0]       w_err_count_nxt;
    logic [WIDTH-1:0] w_diff;

    // Bits that must change to reach the offered target.
    assign w_diff = q_fb ^ in_target;

    // State and all registered outputs. Reset clears J/K at once, so the
    // driven flip-flops hold their value. Any pending target is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tgt       <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_tgt       <= w_tgt_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    // Next-state logic. J/K are non-zero only for the one cycle spent in
    // DRIVE, and done/err are mutually exclusive pulses when CHECK ends.
    always_comb begin
        w_state_nxt     = r_state;
        w_tgt_nxt       = r_tgt;
        w_j_nxt         = '0;
        w_k_nxt         = '0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_err_count_nxt = r_err_count;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_tgt_nxt = in_target;
                    if (USE_TOGGLE) begin
                        w_j_nxt = w_diff;
                        w_k_nxt = w_diff;
                    end else begin
                        w_j_nxt = w_diff & in_target;
                        w_k_nxt = w_diff & ~in_target;
                    end
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Always exactly one cycle, even when nothing changes.
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (q_fb == r_tgt) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                    if (r_err_count != 8'hFF) begin
                        w_err_count_nxt = r_err_count + 8'd1;
                    end
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign j         = r_j;
    assign k         = r_k;
    assign done      = r_done;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign dbg_state = r_state;

endmodule
